// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Shares one 4-input mux between four requesters. A round-robin picker
//   chooses one winner per cycle. The selected word is loaded into a
//   one-entry output buffer, which has a valid/ready handshake toward the
//   consumer.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req[3:0]    req[i]: requester i+1 presents a word on din(i+1)
//   din1..din4  requester words (WIDTH)
//   gnt[3:0]    one-hot accept strobe, combinational; the granted word is
//               captured at this rising edge
//   dout        buffered output word (registered)
//   dout_valid  dout holds an unconsumed word (registered)
//   dout_ready  consumer takes dout at an edge with dout_valid & dout_ready
//   last_grant  index of the most recently granted requester (registered)

// Plain 4:1 word mux used on the shared data path.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [WIDTH-1:0] din4,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [1:0]       last_grant
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             can_load;
  logic             found;
  logic [1:0]       winner;
  logic [WIDTH-1:0] mux_y;

  // Loading is allowed when the buffer is empty or is being drained at
  // this same edge, which keeps one word per cycle under full flow.
  assign can_load = (state == EMPTY) | dout_ready;

  // Round-robin search starting just after the last winner. The 2-bit add
  // wraps 3 -> 0, and k=4 lands on last_grant itself, so the previous
  // winner is examined last.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = last_grant + 2'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // gnt depends only on req, dout_ready, state and last_grant; din never
  // reaches it.
  assign gnt = (can_load && found && !rst) ? (4'b0001 << winner) : 4'b0000;

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .d0  (din1),
    .d1  (din2),
    .d2  (din3),
    .d3  (din4),
    .sel (winner),
    .y   (mux_y)
  );

  // Buffer FSM. dout_valid mirrors the state but is kept as its own flop so
  // the output is driven straight from a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      dout       <= '0;
      dout_valid <= 1'b0;
      last_grant <= 2'b11;   // requester 0 gets first priority
    end else begin
      case (state)
        EMPTY: begin
          if (|gnt) begin
            state      <= FULL;
            dout       <= mux_y;
            dout_valid <= 1'b1;
            last_grant <= winner;
          end
        end
        FULL: begin
          if (|gnt) begin
            // drain and refill at the same edge
            dout       <= mux_y;
            dout_valid <= 1'b1;
            last_grant <= winner;
          end else if (dout_ready) begin
            // drained with nothing to refill; dout keeps its last word
            state      <= EMPTY;
            dout_valid <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] din1, din2, din3, din4;
  logic [3:0]       gnt;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [1:0]       last_grant;

  int n_chk  = 0;
  int n_fail = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .din4       (din4),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buffer is a flag + word; the arbiter is a plain modular search.
  bit       m_ok = 0;
  bit       m_valid;
  int       m_dout;
  int       m_last;

  function automatic int pick(input bit valid, input bit rdy, input logic [3:0] r, input int last);
    if (valid && !rdy) return -1;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int word_of(input int idx);
    case (idx)
      0: return int'(din1);
      1: return int'(din2);
      2: return int'(din3);
      default: return int'(din4);
    endcase
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_valid <= 0;
      m_dout  <= 0;
      m_last  <= 3;
      m_ok    <= 1;
    end else if (m_ok) begin
      w = pick(m_valid, dout_ready, req, m_last);
      if (w >= 0) begin
        m_valid <= 1;
        m_dout  <= word_of(w);
        m_last  <= w;
      end else if (dout_ready) begin
        m_valid <= 0;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    int w;
    logic [3:0] eg;
    if (m_ok) begin
      w  = pick(m_valid, dout_ready, req, m_last);
      eg = (rst || w < 0) ? 4'b0000 : (4'b0001 << w);
      chk("model_gnt",   32'(gnt),        32'(eg));
      chk("model_valid", 32'(dout_valid), 32'(m_valid));
      chk("model_dout",  32'(dout),       32'(m_dout));
      chk("model_last",  32'(last_grant), 32'(m_last));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    rst = 1; req = 4'b0000; dout_ready = 1;
    din1 = '0; din2 = '0; din3 = '0; din4 = '0;
    @(posedge clk); tick();
    chk("rst_gnt",   32'(gnt), 32'h0);
    chk("rst_dout",  32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_last",  32'(last_grant), 32'h3);

    // single requester right after reset
    rst = 0; req = 4'b0100; din3 = 8'hA5;
    #2 chk("single_gnt", 32'(gnt), 32'h4);
    tick();
    chk("single_dout",  32'(dout), 32'hA5);
    chk("single_valid", 32'(dout_valid), 32'h1);
    chk("single_last",  32'(last_grant), 32'h2);

    // move last_grant to 3 so contention starts at requester 0
    din1 = 8'h11; din2 = 8'h22; din3 = 8'h33; din4 = 8'h44;
    req = 4'b1000;
    #2 chk("pre_gnt", 32'(gnt), 32'h8);
    tick();

    // full contention, no idle cycles; two extra grants leave 22 buffered
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #2 chk("cont_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
      tick();
      chk("cont_dout", 32'(dout), 32'(seq[i % 4]));
    end
    chk("cont_last", 32'(last_grant), 32'h1);

    // backpressure
    dout_ready = 0; req = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      #2 chk("bp_gnt", 32'(gnt), 32'h0);
      tick();
      chk("bp_dout", 32'(dout), 32'h22);
      chk("bp_last", 32'(last_grant), 32'h1);
    end
    dout_ready = 1;
    #2 chk("bp_release_gnt", 32'(gnt), 32'h4);
    tick();
    chk("bp_release_dout", 32'(dout), 32'h33);

    // wrap-around
    req = 4'b1000;
    #2 chk("wrap_pre_gnt", 32'(gnt), 32'h8);
    tick();
    req = 4'b1001;
    #2 chk("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    #2 chk("wrap_gnt3", 32'(gnt), 32'h8);
    tick();
    #2 chk("wrap_gnt0b", 32'(gnt), 32'h1);
    tick();
    chk("wrap_dout", 32'(dout), 32'h11);

    // drain without refill
    req = 4'b0000;
    tick();
    chk("drain_valid", 32'(dout_valid), 32'h0);
    chk("drain_dout",  32'(dout), 32'h11);
    chk("drain_last",  32'(last_grant), 32'h0);

    // reset mid-operation with 44 buffered
    req = 4'b1000;
    tick();
    chk("mid_pre_dout", 32'(dout), 32'h44);
    dout_ready = 0; req = 4'b1111; rst = 1;
    #2 chk("mid_rst_gnt", 32'(gnt), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(dout_valid), 32'h0);
    chk("mid_rst_dout",  32'(dout), 32'h0);
    chk("mid_rst_last",  32'(last_grant), 32'h3);
    rst = 0;
    #2 chk("mid_first_gnt", 32'(gnt), 32'h1);
    tick();

    // deterministic sweep over req/ready combinations, model-checked
    for (int i = 0; i < 64; i++) begin
      req        = 4'((i * 7) % 16);
      dout_ready = (i % 3) != 0;
      din1 = 8'(i * 3 + 1); din2 = 8'(i * 5 + 2);
      din3 = 8'(i * 11 + 3); din4 = 8'(i * 13 + 4);
      tick();
    end

    req = 4'b0000; dout_ready = 1;
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and output register that shares one parameterized 4-input mux between four requesters. Each requester presents a word and a request. The block picks one winner per cycle, drives the mux select, and captures the selected word into a one-entry output buffer. The buffer has a valid/ready handshake toward the downstream consumer. It sits between four producer channels and a single shared downstream datapath, and instantiates the existing 4-input mux for the data path.

## Interface
- WIDTH, 8, data width of every requester word and of dout
- clk  input  1  rising-edge clock, sole clock of the block
- rst  input  1  reset, synchronous and active-high
- req  input  4  req[i]=1: requester i+1 has a word on din(i+1); held until granted
- din1, din2, din3, din4  input  WIDTH  requester words, stable while the matching req is 1
- gnt  output  4  one-hot accept strobe, combinational; gnt[i]=1 means din(i+1) is captured at this rising edge
- dout  output  WIDTH  buffered output word (registered)
- dout_valid  output  1  dout holds an unconsumed word (registered)
- dout_ready  input  1  consumer accepts dout at the edge where dout_valid & dout_ready
- last_grant  output  2  index of the most recently granted requester (registered)

## Operation
- Buffer state machine, two states.
  - EMPTY: dout_valid=0.
  - FULL: dout_valid=1.
- can_load = (state==EMPTY) | dout_ready. Loading is allowed whenever the buffer is empty or is being drained this cycle.
- Priority order is last_grant+1, +2, +3, +4, all mod 4, so the last winner has the lowest priority. Wrap from 3 to 0 is modulo-4.
- Winner is the first index in priority order with req set. gnt = onehot(winner) when can_load & |req & !rst, else 4'b0000.
- The mux select is the winner index. The mux output feeds the dout register.
- On a rising edge with |gnt:
  - dout <= selected din
  - dout_valid <= 1
  - last_grant <= winner
- On a rising edge with no gnt:
  - if dout_ready & dout_valid: dout_valid <= 0. dout keeps its last value.
  - else: state unchanged.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on a grant with simultaneous drain, or on dout_ready=0.
  - FULL→EMPTY on a drain with no grant.
- Backpressure: while FULL and dout_ready=0, gnt=0. dout, dout_valid and last_grant are frozen. No word is lost or overwritten.
- A requester whose req drops before it is granted is simply skipped. A requester may not change din while req=1 and ungranted.
- A requester that is granted and keeps req=1 is treated as presenting a new word on the next cycle.

## Timing
- Reset values after any edge with rst=1:
  - dout = 0
  - dout_valid = 0
  - last_grant = 2'b11, so requester 0 (din1) has first priority
  - gnt = 0 while rst=1
- Reset mid-operation: a buffered, unconsumed word is discarded. The block is EMPTY after the reset edge. The first grant can occur in the first cycle with rst=0.
- Latency: a word granted at edge k is on dout with dout_valid=1 after edge k, so the consumer can take it at edge k+1.
- Throughput: with dout_ready held at 1, one word per cycle. With all four req held, grant order is 0,1,2,3,0,… with no idle cycle.
- Fairness: a continuously requesting channel is granted within 4 grants.
- gnt is purely combinational from req, dout_ready, state and last_grant. It has no path from din.

## Test plan
- Reset then single requester: rst high 2 cycles; then req=4'b0100, din3=8'hA5, dout_ready=1.
  - Required: gnt=4'b0100 in the first cycle.
  - Required: dout=8'hA5, dout_valid=1 next cycle, last_grant=2.
- Full contention: req=4'b1111 held for 8 cycles, dout_ready=1, din1..4 = 8'h11, 8'h22, 8'h33, 8'h44.
  - Required: dout sequence 11,22,33,44,11,22,33,44 on consecutive cycles.
- Backpressure: buffer FULL with 8'h22 and last_grant=1; dout_ready=0 for 3 cycles with req=4'b1101.
  - Required: gnt=0 and dout=8'h22 stable throughout.
  - Then dout_ready=1: required gnt=4'b0100 (index 2 next after 1) in the same cycle, and dout=8'h33 next.
- Wrap-around: last_grant=3, req=4'b1001.
  - Required: gnt=4'b0001 (index 0), then gnt=4'b1000 (index 3), then 4'b0001.
- Drain without refill: FULL, req=0, dout_ready=1 for one cycle.
  - Required: dout_valid=0 after the edge, dout unchanged, last_grant unchanged.
- Reset mid-operation: FULL with 8'h44 and dout_ready=0; assert rst for 1 cycle with req=4'b1111.
  - Required: gnt=0 during reset.
  - Required after the reset edge: dout_valid=0, dout=0, last_grant=3.
  - Required: next cycle gnt=4'b0001.
